uart_tx_scheduler: RTL and testbench

Sequences the UART transmitter for multiplayer games, and is the transmit-side counterpart of the receive-side message comparator. Two message sources share the single UART TX: a periodic "ready" beacon ('R', 8'h52) and a one-shot "lose" notice ('L', 8'h4C). The block latches requests, arbitrates with fixed priority and hands exactly one byte at a time to the UART TX through a write/done handshake. A timeout triggers retry.

---
 rtl/uart_tx_scheduler_pkg.sv | 13 +
 rtl/uart_tx_scheduler_if.sv | 23 ++
 rtl/uart_tx_scheduler_beacon_timer.sv | 39 +++
 rtl/uart_tx_scheduler.sv | 130 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Game/UART constants shared by the transmit scheduler and the receive-side comparator.
package uart_tx_scheduler_pkg;

  localparam logic [7:0] CHAR_READY = 8'h52;  // 'R' beacon
  localparam logic [7:0] CHAR_LOSE  = 8'h4C;  // 'L' lose notice

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Write/done handshake between the scheduler and the UART transmitter.
interface uart_tx_scheduler_if;

  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_wr,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_wr,
    input  tx_data,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_scheduler_beacon_timer.sv
// Beacon tick generator: pulses on the first enabled cycle and every RESEND_CYCLES after.
module uart_tx_scheduler_beacon_timer #(
  parameter int unsigned RESEND_CYCLES = 6_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned          CNT_W    = $clog2(RESEND_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(RESEND_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             wrap;

  // The first enabled cycle restarts the count, so the next tick lands RESEND_CYCLES later.
  always_comb begin
    wrap  = (cnt_q == CNT_LAST);
    tick  = en & (~en_q | wrap);
    en_d  = en;
    cnt_d = cnt_q + CNT_W'(1);
    if (!en || !en_q || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates 'R' beacon and 'L' lose bytes onto the single UART TX with timeout retry.
module uart_tx_scheduler #(
  parameter int unsigned RESEND_CYCLES = 6_500_000,
  parameter int unsigned TX_TIMEOUT    = 200_000,
  parameter logic [7:0]  CHAR_READY    = uart_tx_scheduler_pkg::CHAR_READY,
  parameter logic [7:0]  CHAR_LOSE     = uart_tx_scheduler_pkg::CHAR_LOSE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       multiplayer,
  input  logic                       play_selected,
  input  logic                       player_lost,
  uart_tx_scheduler_if.master        tx,
  output logic                       lose_sent,
  output logic                       busy
);

  import uart_tx_scheduler_pkg::*;

  localparam int unsigned      TMO_W    = $clog2(TX_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_TIMEOUT - 1);

  tx_state_e        state_q, state_d;
  logic             tx_wr_q, tx_wr_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             lose_sent_q, lose_sent_d;
  logic             busy_q, busy_d;
  logic             lose_pend_q, lose_pend_d;
  logic             ready_pend_q, ready_pend_d;
  logic             lose_done_q, lose_done_d;
  logic             served_lose_q, served_lose_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic beacon_en;
  logic beacon_tick;
  logic lose_req;
  logic ready_req;
  logic done_l;
  logic done_r;
  logic timed_out;

  uart_tx_scheduler_beacon_timer #(
    .RESEND_CYCLES (RESEND_CYCLES)
  ) u_beacon_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (beacon_en),
    .tick (beacon_tick)
  );

  // Request flags, arbitration and transfer sequencing.
  always_comb begin
    beacon_en = multiplayer & play_selected & ~lose_pend_q & ~lose_done_q;
    lose_req  = lose_pend_q & multiplayer;
    ready_req = ready_pend_q & beacon_en;
    done_l    = (state_q == ST_WAIT) & tx.tx_done & served_lose_q;
    done_r    = (state_q == ST_WAIT) & tx.tx_done & ~served_lose_q;
    timed_out = (state_q == ST_WAIT) & ~tx.tx_done & (tmo_cnt_q == TMO_LAST);

    // A request arriving while its flag is already set is absorbed; completion clears it.
    lose_pend_d  = multiplayer & (lose_pend_q ? ~done_l : (player_lost & ~lose_done_q));
    lose_done_d  = multiplayer & play_selected & (lose_done_q | done_l);
    ready_pend_d = beacon_en & (ready_pend_q ? ~done_r : beacon_tick);

    state_d       = state_q;
    tx_wr_d       = 1'b0;
    tx_data_d     = tx_data_q;
    served_lose_d = served_lose_q;
    lose_sent_d   = done_l;
    tmo_cnt_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (!tx.tx_busy && (lose_req || ready_req)) begin
          state_d       = ST_SEND;
          tx_wr_d       = 1'b1;
          served_lose_d = lose_req;
          tx_data_d     = lose_req ? CHAR_LOSE : CHAR_READY;
        end
      end
      ST_SEND: begin
        state_d   = ST_WAIT;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
      ST_WAIT: begin
        if (tx.tx_done || timed_out) begin
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tx_wr_q       <= 1'b0;
      tx_data_q     <= '0;
      lose_sent_q   <= 1'b0;
      busy_q        <= 1'b0;
      lose_pend_q   <= 1'b0;
      ready_pend_q  <= 1'b0;
      lose_done_q   <= 1'b0;
      served_lose_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      tx_wr_q       <= tx_wr_d;
      tx_data_q     <= tx_data_d;
      lose_sent_q   <= lose_sent_d;
      busy_q        <= busy_d;
      lose_pend_q   <= lose_pend_d;
      ready_pend_q  <= ready_pend_d;
      lose_done_q   <= lose_done_d;
      served_lose_q <= served_lose_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign tx.tx_wr   = tx_wr_q;
  assign tx.tx_data = tx_data_q;
  assign lose_sent  = lose_sent_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized traffic.
module tb_uart_tx_scheduler;

  localparam int unsigned RESEND = 50;
  localparam int unsigned TMO    = 20;
  localparam logic [7:0]  BYTE_R = 8'h52;
  localparam logic [7:0]  BYTE_L = 8'h4C;

  logic clk = 1'b0;
  logic rst, multiplayer, play_selected, player_lost, lose_sent, busy;

  uart_tx_scheduler_if tx_if ();

  uart_tx_scheduler #(
    .RESEND_CYCLES (RESEND),
    .TX_TIMEOUT    (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .multiplayer   (multiplayer),
    .play_selected (play_selected),
    .player_lost   (player_lost),
    .tx            (tx_if),
    .lose_sent     (lose_sent),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          cyc      = 0;

  // stimulus for the current cycle
  bit in_rst, in_mp, in_ps, in_pl, in_busy, in_extra_done, tx_done_drv;
  int done_delay = 5;
  int done_at    = -1;

  // observation logs
  int         wr_cycles[$];
  logic [7:0] wr_bytes[$];
  int         ls_cycles[$];
  int         busy_cycles;

  // reference model: transfer in flight with age since its strobe, request flags,
  // beacon age counted in consecutive enabled cycles
  bit          m_inflight, m_is_lose, m_lose_pend, m_ready_pend, m_lose_done;
  int unsigned m_since, m_age;
  logic [7:0]  m_data;
  bit          e_wr, e_busy, e_lose_sent;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int wr_at(input int i);
    return (wr_cycles.size() > i) ? wr_cycles[i] : -1;
  endfunction

  function automatic int byte_at(input int i);
    return (wr_bytes.size() > i) ? int'(wr_bytes[i]) : -1;
  endfunction

  function automatic int ls_at(input int i);
    return (ls_cycles.size() > i) ? ls_cycles[i] : -1;
  endfunction

  task automatic clear_logs();
    wr_cycles.delete();
    wr_bytes.delete();
    ls_cycles.delete();
    busy_cycles = 0;
  endtask

  task automatic model_step();
    bit en, tick, done, tmo, done_l, done_r, launch;
    bit n_lose_pend, n_lose_done, n_ready_pend;
    if (in_rst) begin
      m_inflight   = 1'b0;
      m_is_lose    = 1'b0;
      m_lose_pend  = 1'b0;
      m_ready_pend = 1'b0;
      m_lose_done  = 1'b0;
      m_since      = 0;
      m_age        = 0;
      m_data       = 8'h00;
      e_lose_sent  = 1'b0;
    end else begin
      en     = in_mp && in_ps && !m_lose_pend && !m_lose_done;
      tick   = en && (m_age % RESEND == 0);
      done   = m_inflight && (m_since >= 1) && tx_done_drv;
      tmo    = m_inflight && (m_since >= 1) && !tx_done_drv && (m_since == TMO - 1);
      done_l = done && m_is_lose;
      done_r = done && !m_is_lose;
      launch = !m_inflight && !in_busy && in_mp && (m_lose_pend || (m_ready_pend && en));

      n_lose_pend  = in_mp && (m_lose_pend ? !done_l : (in_pl && !m_lose_done));
      n_lose_done  = in_mp && in_ps && (m_lose_done || done_l);
      n_ready_pend = en && (m_ready_pend ? !done_r : tick);
      m_age        = en ? m_age + 1 : 0;
      e_lose_sent  = done_l;

      if (launch) begin
        m_inflight = 1'b1;
        m_since    = 0;
        m_is_lose  = m_lose_pend;
        m_data     = m_lose_pend ? BYTE_L : BYTE_R;
      end else if (m_inflight) begin
        if (done || tmo) m_inflight = 1'b0;
        else             m_since++;
      end
      m_lose_pend  = n_lose_pend;
      m_lose_done  = n_lose_done;
      m_ready_pend = n_ready_pend;
    end
    e_wr   = m_inflight && (m_since == 0);
    e_busy = m_inflight;
  endtask

  task automatic step_cycle();
    @(negedge clk);
    cyc++;
    check("tx_wr",     32'(tx_if.tx_wr),   32'(e_wr));
    check("tx_data",   32'(tx_if.tx_data), 32'(m_data));
    check("busy",      32'(busy),          32'(e_busy));
    check("lose_sent", 32'(lose_sent),     32'(e_lose_sent));
    if (tx_if.tx_wr) begin
      wr_cycles.push_back(cyc);
      wr_bytes.push_back(tx_if.tx_data);
    end
    if (lose_sent) ls_cycles.push_back(cyc);
    if (busy) busy_cycles++;
    // UART stand-in: answers the expected strobe after done_delay cycles (never if negative)
    if (e_wr) done_at = (done_delay >= 0) ? cyc + done_delay : -1;
    tx_done_drv      = (cyc == done_at) || in_extra_done;
    rst              = in_rst;
    multiplayer      = in_mp;
    play_selected    = in_ps;
    player_lost      = in_pl;
    tx_if.tx_busy    = in_busy;
    tx_if.tx_done    = tx_done_drv;
    model_step();
    in_pl         = 1'b0;
    in_extra_done = 1'b0;
  endtask

  initial begin
    int e0, n0, p0, q0, l0, s0;

    in_rst = 1'b1; in_mp = 1'b0; in_ps = 1'b0; in_pl = 1'b0;
    in_busy = 1'b0; in_extra_done = 1'b0; tx_done_drv = 1'b0;
    rst = 1'b1; multiplayer = 1'b0; play_selected = 1'b0; player_lost = 1'b0;
    tx_if.tx_busy = 1'b0; tx_if.tx_done = 1'b0;
    model_step();
    repeat (2) @(posedge clk);
    step_cycle();
    in_rst = 1'b0;

    // beacon: first 'R' two cycles after enabling, then every RESEND cycles, busy 6 cycles each
    in_mp = 1'b1; in_ps = 1'b0; done_delay = 5;
    repeat (3) step_cycle();
    clear_logs();
    in_ps = 1'b1;
    e0 = cyc + 1;
    repeat (110) step_cycle();
    check("t1_first_R",     32'(wr_at(0)), 32'(e0 + 2));
    check("t1_second_R",    32'(wr_at(1)), 32'(e0 + 52));
    check("t1_third_R",     32'(wr_at(2)), 32'(e0 + 102));
    check("t1_wr_count",    32'(wr_cycles.size()), 32'd3);
    check("t1_busy_cycles", 32'(busy_cycles), 32'd18);
    check("t1_byte",        32'(byte_at(0)), 32'(BYTE_R));

    // lose notice: strobe at N+2, lose_sent after done, beacon silenced until play_selected toggles
    clear_logs();
    n0 = cyc + 1;
    in_pl = 1'b1;
    repeat (80) step_cycle();
    check("t2_L_latency",   32'(wr_at(0)), 32'(n0 + 2));
    check("t2_L_byte",      32'(byte_at(0)), 32'(BYTE_L));
    check("t2_wr_count",    32'(wr_cycles.size()), 32'd1);
    check("t2_ls_cycle",    32'(ls_at(0)), 32'(n0 + 8));
    check("t2_ls_count",    32'(ls_cycles.size()), 32'd1);
    in_ps = 1'b0;
    repeat (2) step_cycle();
    clear_logs();
    in_ps = 1'b1;
    p0 = cyc + 1;
    repeat (10) step_cycle();
    check("t2_R_after_toggle", 32'(wr_at(0)), 32'(p0 + 2));
    check("t2_R_byte",         32'(byte_at(0)), 32'(BYTE_R));

    // lose during an 'R' wait: 'R' finishes, 'L' follows two cycles after its done
    in_ps = 1'b0;
    repeat (2) step_cycle();
    clear_logs();
    in_ps = 1'b1;
    q0 = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      in_pl = (cyc + 1 == q0 + 4);
      step_cycle();
    end
    check("t3_R_wr",     32'(wr_at(0)), 32'(q0 + 2));
    check("t3_L_wr",     32'(wr_at(1)), 32'(q0 + 9));
    check("t3_L_byte",   32'(byte_at(1)), 32'(BYTE_L));
    check("t3_wr_count", 32'(wr_cycles.size()), 32'd2);
    check("t3_ls_count", 32'(ls_cycles.size()), 32'd1);
    check("t3_ls_cycle", 32'(ls_at(0)), 32'(q0 + 15));

    // no tx_done: 'L' retried every TMO+1 cycles until the UART finally answers
    in_ps = 1'b0;
    repeat (2) step_cycle();
    clear_logs();
    done_delay = -1;
    l0 = cyc + 1;
    in_pl = 1'b1;
    for (int i = 0; i < 90; i++) begin
      if (cyc + 1 == l0 + 50) done_delay = 5;
      step_cycle();
    end
    check("t4_first_wr",  32'(wr_at(0)), 32'(l0 + 2));
    check("t4_retry_wr",  32'(wr_at(1)), 32'(l0 + 23));
    check("t4_last_wr",   32'(wr_at(3)), 32'(l0 + 65));
    check("t4_wr_count",  32'(wr_cycles.size()), 32'd4);
    check("t4_ls_count",  32'(ls_cycles.size()), 32'd1);
    check("t4_ls_cycle",  32'(ls_at(0)), 32'(l0 + 71));

    // single-player: nothing is ever sent
    in_mp = 1'b0; in_ps = 1'b1;
    clear_logs();
    for (int i = 0; i < 200; i++) begin
      in_pl = ($urandom_range(0, 9) == 0);
      step_cycle();
    end
    check("t5_wr_count",   32'(wr_cycles.size()), 32'd0);
    check("t5_busy_count", 32'(busy_cycles), 32'd0);
    check("t5_ls_count",   32'(ls_cycles.size()), 32'd0);

    // reset while waiting on 'L': silent abandon
    in_mp = 1'b1; in_ps = 1'b0; done_delay = -1;
    s0 = cyc + 1;
    in_pl = 1'b1;
    repeat (5) step_cycle();
    check("t6_in_wait", 32'(busy), 32'd1);
    in_rst = 1'b1;
    step_cycle();
    in_rst = 1'b0;
    clear_logs();
    step_cycle();
    check("t6_busy_after_rst", 32'(busy), 32'd0);
    check("t6_wr_after_rst",   32'(tx_if.tx_wr), 32'd0);
    check("t6_data_after_rst", 32'(tx_if.tx_data), 32'd0);
    repeat (60) step_cycle();
    check("t6_wr_count", 32'(wr_cycles.size()), 32'd0);
    check("t6_ls_count", 32'(ls_cycles.size()), 32'd0);
    check("t6_strobe_seen_before", 32'(s0 > 0), 32'd1);

    // randomized traffic against the model
    in_mp = 1'b1; in_ps = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) in_mp = ~in_mp;
      if ($urandom_range(0, 79) == 0)  in_ps = ~in_ps;
      in_pl         = ($urandom_range(0, 39) == 0);
      in_busy       = ($urandom_range(0, 4) == 0);
      in_extra_done = ($urandom_range(0, 99) == 0);
      in_rst        = ($urandom_range(0, 499) == 0);
      done_delay    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 24));
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
